// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the imem req/ack handshake, and resolves
// branch/jump redirects (jump > branch > sequential), buffering one across stalls.
module pc_fetch_ctrl #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  output logic             instr_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [1:0]       pc_sel,
  output logic             redirect_pending,
  output logic             misalign_err
);

  typedef enum logic [1:0] {BOOT, REQ, RETIRE} state_t;

  localparam logic [1:0]       SEL_SEQ = 2'b00;
  localparam logic [1:0]       SEL_BR  = 2'b01;
  localparam logic [1:0]       SEL_JMP = 2'b10;
  localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VEC);

  state_t           state_q;
  logic             req_q;
  logic             vld_q;
  logic [WIDTH-1:0] pc_q;
  logic             pend_q;
  logic [1:0]       buf_sel_q;
  logic [WIDTH-1:0] buf_tgt_q;
  logic             mis_q;

  logic [1:0]       live_sel;
  logic [WIDTH-1:0] live_tgt;
  logic [1:0]       eff_sel;
  logic [WIDTH-1:0] eff_tgt;
  logic [1:0]       sel_d;
  logic [WIDTH-1:0] pc_plus4_d;
  logic [WIDTH-1:0] pc_d;
  logic             capture;

  // A buffered redirect takes precedence over whatever the live inputs say.
  always_comb begin
    live_sel   = jump ? SEL_JMP : (branch_taken ? SEL_BR : SEL_SEQ);
    live_tgt   = jump ? jump_target : branch_target;
    eff_sel    = pend_q ? buf_sel_q : live_sel;
    eff_tgt    = pend_q ? buf_tgt_q : live_tgt;
    sel_d      = (state_q == RETIRE) ? eff_sel : SEL_SEQ;
    pc_plus4_d = pc_q + WIDTH'(4);
    pc_d       = (sel_d == SEL_SEQ) ? pc_plus4_d : {eff_tgt[WIDTH-1:2], 2'b00};
    capture    = (state_q == RETIRE) && stall && !pend_q && (jump || branch_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      req_q     <= 1'b0;
      vld_q     <= 1'b0;
      pc_q      <= RST_PC;
      pend_q    <= 1'b0;
      buf_sel_q <= SEL_SEQ;
      mis_q     <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            state_q <= RETIRE;
            req_q   <= 1'b0;
            vld_q   <= 1'b1;
          end
        end
        RETIRE: begin
          if (stall) begin
            if (capture) begin
              pend_q    <= 1'b1;
              buf_sel_q <= live_sel;
            end
          end else begin
            pc_q      <= pc_d;
            pend_q    <= 1'b0;
            buf_sel_q <= SEL_SEQ;
            if ((sel_d != SEL_SEQ) && (eff_tgt[1:0] != 2'b00))
              mis_q <= 1'b1;
            state_q <= REQ;
            req_q   <= 1'b1;
            vld_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= BOOT;
          req_q   <= 1'b0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  // Target is only meaningful while pend_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (capture)
      buf_tgt_q <= live_tgt;
  end

  assign imem_req         = req_q;
  assign imem_addr        = pc_q;
  assign instr_valid      = vld_q;
  assign pc               = pc_q;
  assign pc_plus4         = pc_plus4_d;
  assign pc_sel           = sel_d;
  assign redirect_pending = pend_q;
  assign misalign_err     = mis_q;

endmodule
